data_ram_responder: RTL and testbench

- Responder end of the memory-access stage's data interface: receives load/store requests, owns the data RAM array, and returns load data or completion.
- Performs little-endian byte-lane steering for byte/half/word stores and for sign/zero-extended loads.
- Inserts a configurable number of wait states and flags misaligned or out-of-range accesses.
- Sits between the memory-access stage and the data RAM; the stage stalls on req_ready low.

---
 rtl/data_ram_pkg.sv | 26 ++
 rtl/data_ram_responder_align.sv | 47 ++++
 rtl/data_ram_responder.sv | 115 +++++++++++
 tb/tb_data_ram_responder.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/data_ram_pkg.sv
// Shared encodings and helpers for the data RAM responder.
package data_ram_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_BAD  = 2'd3;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] WAIT   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    function automatic logic misaligned(input logic [1:0] lane,
                                        input logic [1:0] size);
        logic m;
        m = 1'b0;
        case (size)
            SZ_HALF: m = lane[0];
            SZ_WORD: m = (lane != 2'd0);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/data_ram_responder_align.sv
// Little-endian byte-lane steering for stores and extended loads.
module mem_lane_align
    import data_ram_pkg::*;
(
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic [31:0] rdata
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        be         = 4'b0000;
        lane_wdata = wdata;
        case (size)
            SZ_BYTE: begin
                be         = 4'b0001 << lane;
                lane_wdata = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be         = lane[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata[15:0]}};
            end
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_comb begin
        rbyte = rword[{lane, 3'b000} +: 8];
        rhalf = rword[{lane[1], 4'b0000} +: 16];
        rdata = 32'd0;
        case (size)
            SZ_BYTE: rdata = {{24{sign & rbyte[7]}}, rbyte};
            SZ_HALF: rdata = {{16{sign & rhalf[15]}}, rhalf};
            SZ_WORD: rdata = rword;
            default: rdata = 32'd0;
        endcase
    end

endmodule

// File: rtl/data_ram_responder.sv
// Data RAM responder: request latch, wait-state FSM and word array.
module data_ram_responder
    import data_ram_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [2:0] CNT_INIT =
        3'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    logic [1:0]    state;
    logic [2:0]    cnt;
    logic          wr_q;
    logic [1:0]    size_q;
    logic          sign_q;
    logic [1:0]    lane_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic          err_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic        bad;
    logic [31:0] rword;
    logic [3:0]  be;
    logic [31:0] lane_wdata;
    logic [31:0] ld_data;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign accept     = req_valid && req_ready;

    assign bad = (req_size == SZ_BAD)
              || misaligned(req_addr[1:0], req_size)
              || ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));

    assign rword = mem[idx_q];

    mem_lane_align u_align (
        .lane       (lane_q),
        .size       (size_q),
        .sign       (sign_q),
        .wdata      (wdata_q),
        .rword      (rword),
        .be         (be),
        .lane_wdata (lane_wdata),
        .rdata      (ld_data)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            wr_q       <= 1'b0;
            size_q     <= 2'd0;
            sign_q     <= 1'b0;
            lane_q     <= 2'd0;
            idx_q      <= '0;
            wdata_q    <= 32'd0;
            err_q      <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    wr_q    <= req_wr;
                    size_q  <= req_size;
                    sign_q  <= req_sign;
                    lane_q  <= req_addr[1:0];
                    idx_q   <= req_addr[AW+1:2];
                    wdata_q <= req_wdata;
                    err_q   <= bad;
                    cnt     <= CNT_INIT;
                    state   <= (WAIT_CYCLES == 0) ? ACCESS : WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd0) state <= ACCESS;
                end
                ACCESS: begin
                    resp_err   <= err_q;
                    resp_rdata <= (err_q || wr_q) ? 32'd0 : ld_data;
                    state      <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Array has no reset; the write is gated by the reset-controlled FSM.
    always_ff @(posedge clk) begin
        if (state == ACCESS && wr_q && !err_q) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx_q][8*b +: 8] <= lane_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_ram_responder.sv
// Directed bench for data_ram_responder with one and zero wait states.
module tb_data_ram_responder;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        rq_v = 1'b0;
    logic        req_wr = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_sign = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    bit          sel = 1'b0;

    logic        v1, v0, rr1, rr0, rv1, rv0, re1, re0;
    logic [31:0] rd1, rd0;
    logic        rr, rv, re;
    logic [31:0] rd;

    int checks = 0;
    int errors = 0;
    int lat;

    assign v1 = sel ? 1'b0 : rq_v;
    assign v0 = sel ? rq_v : 1'b0;
    assign rr = sel ? rr0 : rr1;
    assign rv = sel ? rv0 : rv1;
    assign re = sel ? re0 : re1;
    assign rd = sel ? rd0 : rd1;

    always #5 clk = ~clk;

    data_ram_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(v1), .req_ready(rr1),
        .req_wr(req_wr), .req_size(req_size), .req_sign(req_sign),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv1), .resp_rdata(rd1), .resp_err(re1)
    );

    data_ram_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rstn(rstn),
        .req_valid(v0), .req_ready(rr0),
        .req_wr(req_wr), .req_size(req_size), .req_sign(req_sign),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv0), .resp_rdata(rd0), .resp_err(re0)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    task automatic xact(input string tag, input logic wr,
                        input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee,
                        input bit hold);
        @(negedge clk);
        req_wr    = wr;
        req_size  = sz;
        req_sign  = sg;
        req_addr  = a;
        req_wdata = wd;
        rq_v      = 1'b1;
        chk({tag, "_rdy"}, rr, 1'b1);
        @(posedge clk);
        #1;
        if (!hold) rq_v = 1'b0;
        req_wr    = ~wr;
        req_size  = 2'd3;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'h5A5A_5A5A;
        chk({tag, "_busy"}, rr, 1'b0);
        for (int i = 0; i < lat; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_early"}, rv, 1'b0);
            chk({tag, "_busyw"}, rr, 1'b0);
        end
        @(posedge clk);
        #1;
        chk({tag, "_vld"}, rv, 1'b1);
        chk({tag, "_rdata"}, rd, er);
        chk({tag, "_err"}, re, ee);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, rv, 1'b0);
        chk({tag, "_idle"}, rr, 1'b1);
        chk({tag, "_hold"}, rd, er);
    endtask

    initial begin
        lat = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", rr, 1'b1);
        chk("rst_valid", rv, 1'b0);
        chk("rst_rdata", rd, 32'd0);
        chk("rst_err", re, 1'b0);
        @(negedge clk);
        rstn = 1'b1;

        xact("sw10", 1, 2'd2, 0, 32'h10, 32'h1234_5678, 32'h0, 0, 0);
        xact("lw10", 0, 2'd2, 0, 32'h10, 32'h0, 32'h1234_5678, 0, 0);
        xact("sb11", 1, 2'd0, 0, 32'h11, 32'hFFFF_FFAB, 32'h0, 0, 0);
        xact("lb11", 0, 2'd0, 1, 32'h11, 32'h0, 32'hFFFF_FFAB, 0, 0);
        xact("lbu11", 0, 2'd0, 0, 32'h11, 32'h0, 32'h0000_00AB, 0, 0);
        xact("lw10b", 0, 2'd2, 1, 32'h10, 32'h0, 32'h1234_AB78, 0, 0);
        xact("sh12", 1, 2'd1, 0, 32'h12, 32'h0000_8001, 32'h0, 0, 0);
        xact("lh12", 0, 2'd1, 1, 32'h12, 32'h0, 32'hFFFF_8001, 0, 0);
        xact("lhu12", 0, 2'd1, 0, 32'h12, 32'h0, 32'h0000_8001, 0, 0);
        xact("lw10h", 0, 2'd2, 0, 32'h10, 32'h0, 32'h8001_AB78, 0, 0);
        xact("lb13", 0, 2'd0, 1, 32'h13, 32'h0, 32'hFFFF_FF80, 0, 0);

        xact("lh13", 0, 2'd1, 1, 32'h13, 32'h0, 32'h0, 1, 0);
        xact("sw16", 1, 2'd2, 0, 32'h16, 32'hFFFF_FFFF, 32'h0, 1, 0);
        xact("sz3", 1, 2'd3, 0, 32'h10, 32'hFFFF_FFFF, 32'h0, 1, 0);
        xact("lwoor", 0, 2'd2, 0, 32'h1000, 32'h0, 32'h0, 1, 0);
        xact("swoor", 1, 2'd2, 0, 32'h1010, 32'hFFFF_FFFF, 32'h0, 1, 0);
        xact("lwchk", 0, 2'd2, 0, 32'h10, 32'h0, 32'h8001_AB78, 0, 0);

        xact("b2b_a", 1, 2'd2, 0, 32'h20, 32'hCAFE_F00D, 32'h0, 0, 1);
        xact("b2b_b", 0, 2'd0, 0, 32'h22, 32'h0, 32'h0000_00FE, 0, 1);
        xact("b2b_c", 0, 2'd2, 0, 32'h20, 32'h0, 32'hCAFE_F00D, 0, 0);

        sel = 1'b1;
        lat = 0;
        xact("w0_sw", 1, 2'd2, 0, 32'h8, 32'h0BAD_F00D, 32'h0, 0, 1);
        xact("w0_lh", 0, 2'd1, 1, 32'hA, 32'h0, 32'h0000_0BAD, 0, 1);
        xact("w0_lw", 0, 2'd2, 0, 32'h8, 32'h0, 32'h0BAD_F00D, 0, 0);
        xact("w0_err", 0, 2'd2, 0, 32'h9, 32'h0, 32'h0, 1, 0);
        sel = 1'b0;
        lat = 1;

        xact("prerst", 0, 2'd2, 0, 32'h20, 32'h0, 32'hCAFE_F00D, 0, 0);
        @(negedge clk);
        req_wr    = 1'b1;
        req_size  = 2'd2;
        req_addr  = 32'h20;
        req_wdata = 32'hDEAD_BEEF;
        rq_v      = 1'b1;
        @(posedge clk);
        #1;
        rq_v = 1'b0;
        chk("mid_busy", rr, 1'b0);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("mid_valid", rv, 1'b0);
        chk("mid_rdata", rd, 32'd0);
        chk("mid_err", re, 1'b0);
        chk("mid_ready", rr, 1'b1);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("mid_noresp", rv, 1'b0);
        end
        xact("postrst", 0, 2'd2, 0, 32'h20, 32'h0, 32'hCAFE_F00D, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
